// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of one data-memory port between
// the CPU load/store unit (req0) and the DMA/debug loader (req1).
// Optional ownership lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_port_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_loadtype,
  input  logic [3:0]        req0_storetype,
  input  logic              req0_lock,
  output logic              req0_ack,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_loadtype,
  input  logic [3:0]        req1_storetype,
  input  logic              req1_lock,
  output logic              req1_ack,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_loadtype,
  output logic [3:0]        mem_storetype,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic last_grant;
  logic rsp_pending;
  logic rsp_tag;
  logic elig0;
  logic elig1;
  logic grant_vld;
  logic grant_id;
  logic sel_we;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             lock_owner;
  logic             lock_owner_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             sel_lock;
`else
  logic lock_unused;
  assign lock_unused = req0_lock ^ req1_lock ^ (LOCK_MAX == 0);
`endif

  // Eligibility (reset and lock masking) and round-robin winner selection
  always_comb begin
    elig0 = reset & req0_valid;
    elig1 = reset & req1_valid;
`ifdef DMEM_ARB_LOCK_EN
    if (state == ST_LOCKED) begin
      if (lock_owner) elig0 = 1'b0;
      else            elig1 = 1'b0;
    end
`endif
    grant_vld = elig0 | elig1;
    grant_id  = (elig0 & elig1) ? ~last_grant : elig1;
  end

  assign sel_we   = grant_id ? req1_we : req0_we;
  assign req0_ack = grant_vld & ~grant_id;
  assign req1_ack = grant_vld & grant_id;

  // Winner's access goes straight onto the memory port; idle port is all zero
  assign mem_write_en  = grant_vld & sel_we;
  assign mem_read_en   = grant_vld & ~sel_we;
  assign mem_addr      = grant_vld ? (grant_id ? req1_addr : req0_addr) : '0;
  assign mem_wdata     = grant_vld ? (grant_id ? req1_wdata : req0_wdata) : '0;
  assign mem_loadtype  = grant_vld ? (grant_id ? req1_loadtype : req0_loadtype) : 4'd0;
  assign mem_storetype = grant_vld ? (grant_id ? req1_storetype : req0_storetype) : 4'd0;

  // Read data steering by the registered response tag
  assign req0_rvalid = rsp_pending & ~rsp_tag;
  assign req1_rvalid = rsp_pending & rsp_tag;
  assign req0_rdata  = req0_rvalid ? mem_rdata : '0;
  assign req1_rdata  = req1_rvalid ? mem_rdata : '0;

  // Round-robin history and load response tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant  <= 1'b1;
      rsp_pending <= 1'b0;
      rsp_tag     <= 1'b0;
    end else begin
      rsp_pending <= grant_vld & ~sel_we;
      if (grant_vld) begin
        last_grant <= grant_id;
        rsp_tag    <= grant_id;
      end
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  assign sel_lock = grant_id ? req1_lock : req0_lock;

  // Lock FSM next state: enter on a locked grant, leave on unlock or run limit
  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    lock_cnt_nxt   = lock_cnt;
    if (grant_vld) begin
      case (state)
        ST_UNLOCKED: begin
          if (sel_lock) begin
            state_nxt      = ST_LOCKED;
            lock_owner_nxt = grant_id;
            lock_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!sel_lock || ((lock_cnt + CNT_W'(1)) >= CNT_W'(LOCK_MAX))) begin
            state_nxt    = ST_UNLOCKED;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // Lock FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_UNLOCKED;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own shadow memory.
module tb_dmem_port_arbiter;

  localparam int unsigned LMAX = 4;
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LD = 4'd3;
  localparam logic [3:0] LBU = 4'd4, LHU = 4'd5, LWU = 4'd6;
  localparam logic [3:0] SB = 4'd0, SH = 4'd1, SW = 4'd2, SD = 4'd3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        v[2];
  logic        we[2];
  logic        lk[2];
  logic [63:0] ad[2];
  logic [63:0] wd[2];
  logic [3:0]  lt[2];
  logic [3:0]  st[2];

  logic        ack0, ack1, rv0, rv1;
  logic [63:0] rd0, rd1;
  logic        mrd_en, mwr_en;
  logic [63:0] maddr, mwdata, mrdata;
  logic [3:0]  mlt, mst;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_last = 1;
  bit          m_pend = 0;
  int          m_tag = 0;
  logic [63:0] m_rdata = '0;
  bit          m_locked = 0;
  int          m_owner = 0;
  int          m_cnt = 0;
  int          m_g = -1;
  logic        obs_ack0, obs_ack1;

  logic [511:0] env_mem = '0;
  logic [511:0] ref_mem = '0;

  dmem_port_arbiter #(.DATA_W(64), .ADDR_W(64), .LOCK_MAX(LMAX)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(v[0]), .req0_we(we[0]), .req0_addr(ad[0]), .req0_wdata(wd[0]),
    .req0_loadtype(lt[0]), .req0_storetype(st[0]), .req0_lock(lk[0]),
    .req0_ack(ack0), .req0_rvalid(rv0), .req0_rdata(rd0),
    .req1_valid(v[1]), .req1_we(we[1]), .req1_addr(ad[1]), .req1_wdata(wd[1]),
    .req1_loadtype(lt[1]), .req1_storetype(st[1]), .req1_lock(lk[1]),
    .req1_ack(ack1), .req1_rvalid(rv1), .req1_rdata(rd1),
    .mem_read_en(mrd_en), .mem_write_en(mwr_en), .mem_addr(maddr),
    .mem_wdata(mwdata), .mem_loadtype(mlt), .mem_storetype(mst),
    .mem_rdata(mrdata)
  );

  always #5 clock = ~clock;

  // Byte-addressed 64-byte memory semantics shared by environment and model
  function automatic logic [63:0] ld_fn(input logic [511:0] m, input logic [63:0] a,
                                        input logic [3:0] t);
    int n; bit sgn; int b; logic [63:0] r;
    b = int'(a[5:0]);
    case (t)
      LB:  begin n = 1; sgn = 1; end
      LH:  begin n = 2; sgn = 1; end
      LW:  begin n = 4; sgn = 1; end
      LBU: begin n = 1; sgn = 0; end
      LHU: begin n = 2; sgn = 0; end
      LWU: begin n = 4; sgn = 0; end
      default: begin n = 8; sgn = 0; end
    endcase
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = m[((b + i) % 64)*8 +: 8];
    if (sgn && r[n*8-1]) for (int i = n*8; i < 64; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [511:0] st_fn(input logic [511:0] m, input logic [63:0] a,
                                         input logic [63:0] d, input logic [3:0] t);
    int n; int b;
    b = int'(a[5:0]);
    case (t)
      SB: n = 1;
      SH: n = 2;
      SW: n = 4;
      default: n = 8;
    endcase
    for (int i = 0; i < n; i++) m[((b + i) % 64)*8 +: 8] = d[i*8 +: 8];
    return m;
  endfunction

  // Memory environment: 1-cycle registered read, garbage when not reading
  always @(posedge clock) begin
    if (mwr_en) env_mem <= st_fn(env_mem, maddr, mwdata, mst);
    if (mrd_en) mrdata <= ld_fn(env_mem, maddr, mlt);
    else        mrdata <= {$urandom, $urandom};
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic setreq(input int n, input logic val, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [3:0] l, input logic [3:0] s,
                        input logic k);
    v[n] = val; we[n] = w; ad[n] = a; wd[n] = d; lt[n] = l; st[n] = s; lk[n] = k;
  endtask

  task automatic model_reset();
    m_last = 1; m_pend = 0; m_locked = 0; m_cnt = 0; m_owner = 0; m_g = -1;
  endtask

  // One clock: predict and check at negedge, advance the model at posedge
  task automatic cycle();
    bit e0, e1; int g;
    @(negedge clock);
    e0 = v[0] && !(m_locked && m_owner == 1);
    e1 = v[1] && !(m_locked && m_owner == 0);
    if (e0 && e1) g = 1 - m_last;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    chk("ack0", 64'(ack0), 64'(g == 0));
    chk("ack1", 64'(ack1), 64'(g == 1));
    chk("rd_en", 64'(mrd_en), 64'(g >= 0 && !we[g >= 0 ? g : 0]));
    chk("wr_en", 64'(mwr_en), 64'(g >= 0 && we[g >= 0 ? g : 0]));
    if (g >= 0) begin
      chk("maddr", maddr, ad[g]);
      chk("mwdata", mwdata, wd[g]);
      chk("mtypes", {56'd0, mlt, mst}, {56'd0, lt[g], st[g]});
    end else begin
      chk("idle_port", {maddr ^ mwdata, 56'd0, mlt, mst}, '0);
    end
    chk("rvalid0", 64'(rv0), 64'(m_pend && m_tag == 0));
    chk("rvalid1", 64'(rv1), 64'(m_pend && m_tag == 1));
    chk("rdata0", rd0, (m_pend && m_tag == 0) ? m_rdata : 64'd0);
    chk("rdata1", rd1, (m_pend && m_tag == 1) ? m_rdata : 64'd0);
    obs_ack0 = ack0;
    obs_ack1 = ack1;
    @(posedge clock);
    m_g = g;
    m_pend = 0;
    if (g >= 0) begin
      m_last = g;
      if (we[g]) ref_mem = st_fn(ref_mem, ad[g], wd[g], st[g]);
      else begin
        m_pend = 1; m_tag = g; m_rdata = ld_fn(ref_mem, ad[g], lt[g]);
      end
`ifdef DMEM_ARB_LOCK_EN
      if (!m_locked) begin
        if (lk[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (!lk[g] || m_cnt >= LMAX) begin m_locked = 0; m_cnt = 0; end
      end
`endif
    end
    #1;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) setreq(n, 1'b1, 1'b0, 64'h8 * n, 64'd0, LD, SD, 1'b0);

    // Reset held with both requesting: everything quiet
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack", {62'd0, ack0, ack1}, '0);
    chk("rst_rvalid", {62'd0, rv0, rv1}, '0);
    chk("rst_en", {62'd0, mrd_en, mwr_en}, '0);
    chk("rst_rdata", rd0 | rd1, '0);
    reset = 1'b1;
    model_reset();

    // Store word then load it back through the other port
    setreq(0, 1'b1, 1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, LD, SW, 1'b0);
    setreq(1, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    cycle();
    setreq(0, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    setreq(1, 1'b1, 1'b0, 64'h10, 64'd0, LW, SB, 1'b0);
    cycle();
    chk("lw_rvalid1", 64'(rv1), 64'd1);
    chk("lw_rdata1", rd1, 64'hFFFF_FFFF_DEAD_BEEF);
    chk("lw_rvalid0", 64'(rv0), 64'd0);

    // Continuous tie of loads alternates starting with req0
    setreq(0, 1'b1, 1'b0, 64'h10, 64'd0, LD, SD, 1'b0);
    setreq(1, 1'b1, 1'b0, 64'h18, 64'd0, LWU, SD, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_alt", 64'(obs_ack0), 64'(i % 2 == 0));
    end

    // Signed vs unsigned byte load of 0x80
    setreq(1, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    setreq(0, 1'b1, 1'b1, 64'h20, 64'h80, LD, SB, 1'b0);
    cycle();
    setreq(0, 1'b1, 1'b0, 64'h20, 64'd0, LB, SB, 1'b0);
    cycle();
    chk("lb_sext", rd0, 64'hFFFF_FFFF_FFFF_FF80);
    setreq(0, 1'b1, 1'b0, 64'h20, 64'd0, LBU, SB, 1'b0);
    cycle();
    chk("lbu_zext", rd0, 64'h80);
    setreq(0, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    cycle();

`ifdef DMEM_ARB_LOCK_EN
    // Locked owner keeps the port for LOCK_MAX grants, then the other wins
    setreq(1, 1'b1, 1'b0, 64'h8, 64'd0, LD, SD, 1'b0);
    cycle();
    setreq(0, 1'b1, 1'b0, 64'h0, 64'd0, LD, SD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lock_run", 64'(obs_ack0), 64'(i < 4));
    end
    setreq(0, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    setreq(1, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    cycle();
`endif

    // Randomized traffic; a request holds its fields until acked
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || m_g == n) begin
          setreq(n, 1'(($urandom % 4) != 0), 1'($urandom % 2), 64'($urandom % 64),
                 {$urandom, $urandom}, 4'($urandom % 7), 4'($urandom % 4),
                 1'($urandom % 2));
        end
      end
      cycle();
    end

    // Reset right after a req1 load ack drops the response
    setreq(0, 1'b0, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    setreq(1, 1'b1, 1'b0, 64'h10, 64'd0, LD, SD, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_mid_rvalid1", 64'(rv1), 64'd0);
    chk("rst_mid_rdata1", rd1, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_rvalid", {62'd0, rv0, rv1}, '0);
    reset = 1'b1;
    model_reset();
    setreq(0, 1'b1, 1'b0, 64'h0, 64'd0, LD, SD, 1'b0);
    setreq(1, 1'b1, 1'b0, 64'h8, 64'd0, LD, SD, 1'b0);
    cycle();
    chk("post_rst_tie", 64'(obs_ack0), 64'd1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
